// File: rtl/hazard_scoreboard_pkg.sv
// rtl/hazard_scoreboard_pkg.sv - shared timing constants and forward-select encodings
package hazard_scoreboard_pkg;

    // Tnew/Tuse reference points: consumed/produced in D, E or M.
    localparam int T_D = 0;
    localparam int T_E = 1;
    localparam int T_M = 2;

    // Forward-select encodings driven onto the bypass muxes.
    typedef enum logic [1:0] {
        FWD_RF = 2'd0,
        FWD_W  = 2'd1,
        FWD_M  = 2'd2,
        FWD_E  = 2'd3
    } fwd_sel_e;

endpackage

// File: rtl/hazard_md_busy.sv
// rtl/hazard_md_busy.sv - mult/div busy counter, loaded when a start sits in E
module hazard_md_busy
    import hazard_scoreboard_pkg::*;
#(
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10,
    parameter int CNT_W    = 4
) (
    input  logic clk,     // clock
    input  logic reset,   // asynchronous, active-high
    input  logic start,   // valid mult/div start currently in E
    input  logic is_div,  // that start is a divide
    output logic busy     // counter nonzero
);

    logic [CNT_W-1:0] cnt;

    // A start reloads the counter even if a previous op is still counting.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (start) begin
            cnt <= is_div ? CNT_W'(DIV_LAT) : CNT_W'(MULT_LAT);
        end else if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign busy = (cnt != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - E/M/W destination scoreboard driving stalls and bypass selects
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int REG_AW   = 5,
    parameter int TW       = 2,
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10,
    parameter int CNT_W    = 4
) (
    input  logic              clk,        // clock
    input  logic              reset,      // asynchronous, active-high
    input  logic [REG_AW-1:0] d_rs,       // D source rs
    input  logic [REG_AW-1:0] d_rt,       // D source rt
    input  logic              d_use_rs,   // D reads rs
    input  logic              d_use_rt,   // D reads rt
    input  logic [TW-1:0]     d_tuse_rs,  // cycles from D until rs consumed
    input  logic [TW-1:0]     d_tuse_rt,  // cycles from D until rt consumed
    input  logic              d_regwrite, // D writes a GPR
    input  logic [REG_AW-1:0] d_a3,       // D destination
    input  logic [TW-1:0]     d_tnew,     // cycles after entering E until result exists
    input  logic              d_md_use,   // D touches the mult/div unit
    input  logic              d_md_start, // D starts a mult/div
    input  logic              d_md_div,   // that start is a divide
    output logic              stall,      // freeze PC and F/D, bubble E
    output logic [1:0]        fwd_rs_d,   // D rs select: RF/W/M/E
    output logic [1:0]        fwd_rt_d,   // D rt select: RF/W/M/E
    output logic [1:0]        fwd_rs_e,   // E rs select: pipe/W/M
    output logic [1:0]        fwd_rt_e,   // E rt select: pipe/W/M
    output logic              fwd_rt_m,   // M rt select: pipe/W
    output logic              md_busy,    // mult/div unit busy
    output logic [31:0]       stall_cnt   // saturating stall-cycle count
);

    // Stage records; only the fields each stage's checks consume are kept.
    logic              e_valid, e_wr, e_md_start, e_md_div;
    logic [REG_AW-1:0] e_a3, e_rs, e_rt;
    logic [TW-1:0]     e_tnew;
    logic              m_valid, m_wr;
    logic [REG_AW-1:0] m_a3, m_rt;
    logic [TW-1:0]     m_tnew;
    logic              w_valid, w_wr;
    logic [REG_AW-1:0] w_a3;

    function automatic logic hit(input logic v, input logic wr,
                                 input logic [REG_AW-1:0] a3,
                                 input logic [REG_AW-1:0] r);
        return v && wr && (a3 == r) && (r != '0);
    endfunction

    // Youngest match wins; a young match whose result is not ready yet
    // hides older copies, the stall logic holds D until it is.
    function automatic logic [1:0] sel_d(input logic eh, input logic mh,
                                         input logic wh,
                                         input logic [TW-1:0] et,
                                         input logic [TW-1:0] mt);
        if (eh) return (et == '0) ? FWD_E : FWD_RF;
        if (mh) return (mt == '0) ? FWD_M : FWD_RF;
        if (wh) return FWD_W;
        return FWD_RF;
    endfunction

    logic e_hit_rs, e_hit_rt, m_hit_rs, m_hit_rt, w_hit_rs, w_hit_rt;
    logic stall_rs, stall_rt, stall_md, e_md_go;

    assign e_hit_rs = hit(e_valid, e_wr, e_a3, d_rs);
    assign e_hit_rt = hit(e_valid, e_wr, e_a3, d_rt);
    assign m_hit_rs = hit(m_valid, m_wr, m_a3, d_rs);
    assign m_hit_rt = hit(m_valid, m_wr, m_a3, d_rt);
    assign w_hit_rs = hit(w_valid, w_wr, w_a3, d_rs);
    assign w_hit_rt = hit(w_valid, w_wr, w_a3, d_rt);

    assign stall_rs = d_use_rs && ((e_hit_rs && (e_tnew > d_tuse_rs)) ||
                                   (m_hit_rs && (m_tnew > d_tuse_rs)));
    assign stall_rt = d_use_rt && ((e_hit_rt && (e_tnew > d_tuse_rt)) ||
                                   (m_hit_rt && (m_tnew > d_tuse_rt)));
    assign e_md_go  = e_valid && e_md_start;
    assign stall_md = d_md_use && (md_busy || e_md_go);
    assign stall    = stall_rs || stall_rt || stall_md;

    assign fwd_rs_d = sel_d(e_hit_rs, m_hit_rs, w_hit_rs, e_tnew, m_tnew);
    assign fwd_rt_d = sel_d(e_hit_rt, m_hit_rt, w_hit_rt, e_tnew, m_tnew);

    assign fwd_rs_e = (hit(m_valid, m_wr, m_a3, e_rs) && (m_tnew == '0)) ? FWD_M :
                      hit(w_valid, w_wr, w_a3, e_rs) ? FWD_W : FWD_RF;
    assign fwd_rt_e = (hit(m_valid, m_wr, m_a3, e_rt) && (m_tnew == '0)) ? FWD_M :
                      hit(w_valid, w_wr, w_a3, e_rt) ? FWD_W : FWD_RF;
    assign fwd_rt_m = hit(w_valid, w_wr, w_a3, m_rt);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            e_valid <= 1'b0; e_wr <= 1'b0; e_md_start <= 1'b0; e_md_div <= 1'b0;
            e_a3 <= '0; e_rs <= '0; e_rt <= '0; e_tnew <= '0;
            m_valid <= 1'b0; m_wr <= 1'b0; m_a3 <= '0; m_rt <= '0; m_tnew <= '0;
            w_valid <= 1'b0; w_wr <= 1'b0; w_a3 <= '0;
            stall_cnt <= '0;
        end else begin
            w_valid <= m_valid;
            w_wr    <= m_wr;
            w_a3    <= m_a3;
            m_valid <= e_valid;
            m_wr    <= e_wr;
            m_a3    <= e_a3;
            m_rt    <= e_rt;
            m_tnew  <= (e_tnew == '0) ? '0 : e_tnew - TW'(1);
            if (stall) begin
                // Bubble fields are zeroed so E/M forwarding sees register 0.
                e_valid <= 1'b0; e_wr <= 1'b0; e_md_start <= 1'b0; e_md_div <= 1'b0;
                e_a3 <= '0; e_rs <= '0; e_rt <= '0; e_tnew <= '0;
            end else begin
                e_valid    <= 1'b1;
                e_wr       <= d_regwrite;
                e_a3       <= d_a3;
                e_rs       <= d_rs;
                e_rt       <= d_rt;
                e_tnew     <= d_tnew;
                e_md_start <= d_md_start;
                e_md_div   <= d_md_start && d_md_div;
            end
            if (stall && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
        end
    end

    hazard_md_busy #(
        .MULT_LAT (MULT_LAT),
        .DIV_LAT  (DIV_LAT),
        .CNT_W    (CNT_W)
    ) u_md_busy (
        .clk    (clk),
        .reset  (reset),
        .start  (e_md_go),
        .is_div (e_md_div),
        .busy   (md_busy)
    );

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb/tb_hazard_scoreboard.sv - randomized and directed checks against a stage-list model
module tb_hazard_scoreboard;

    localparam int REG_AW   = 5;
    localparam int TW       = 2;
    localparam int MULT_LAT = 5;
    localparam int DIV_LAT  = 10;

    logic              clk, reset;
    logic [REG_AW-1:0] d_rs, d_rt, d_a3;
    logic              d_use_rs, d_use_rt, d_regwrite, d_md_use, d_md_start, d_md_div;
    logic [TW-1:0]     d_tuse_rs, d_tuse_rt, d_tnew;
    logic              stall, fwd_rt_m, md_busy;
    logic [1:0]        fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e;
    logic [31:0]       stall_cnt;

    hazard_scoreboard #(
        .REG_AW(REG_AW), .TW(TW), .MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT), .CNT_W(4)
    ) dut (
        .clk(clk), .reset(reset),
        .d_rs(d_rs), .d_rt(d_rt), .d_use_rs(d_use_rs), .d_use_rt(d_use_rt),
        .d_tuse_rs(d_tuse_rs), .d_tuse_rt(d_tuse_rt), .d_regwrite(d_regwrite),
        .d_a3(d_a3), .d_tnew(d_tnew), .d_md_use(d_md_use), .d_md_start(d_md_start),
        .d_md_div(d_md_div), .stall(stall), .fwd_rs_d(fwd_rs_d), .fwd_rt_d(fwd_rt_d),
        .fwd_rs_e(fwd_rs_e), .fwd_rt_e(fwd_rt_e), .fwd_rt_m(fwd_rt_m),
        .md_busy(md_busy), .stall_cnt(stall_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Model: pipe[0]=E, pipe[1]=M, pipe[2]=W, as plain instruction records.
    typedef struct {
        bit valid, wr, md_start, md_div;
        int a3, tnew, rs, rt;
    } rec_t;

    rec_t    pipe[3];
    int      cyc, busy_end;
    longint  exp_cnt;
    int      n_checks, n_fail;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic rec_t empty_rec();
        rec_t r;
        r.valid = 0; r.wr = 0; r.md_start = 0; r.md_div = 0;
        r.a3 = 0; r.tnew = 0; r.rs = 0; r.rt = 0;
        return r;
    endfunction

    function automatic bit mm(int s, int r);
        return pipe[s].valid && pipe[s].wr && pipe[s].a3 == r && r != 0;
    endfunction

    function automatic bit m_busy();
        return cyc < busy_end;
    endfunction

    function automatic bit m_stall();
        bit st = 0;
        for (int s = 0; s < 2; s++) begin
            if (d_use_rs && mm(s, int'(d_rs)) && pipe[s].tnew > int'(d_tuse_rs)) st = 1;
            if (d_use_rt && mm(s, int'(d_rt)) && pipe[s].tnew > int'(d_tuse_rt)) st = 1;
        end
        if (d_md_use && (m_busy() || (pipe[0].valid && pipe[0].md_start))) st = 1;
        return st;
    endfunction

    // First stage holding the register decides; W is always ready.
    function automatic int m_fwd_d(int r);
        for (int s = 0; s < 3; s++) begin
            if (mm(s, r)) begin
                if (s == 2) return 1;
                return (pipe[s].tnew == 0) ? 3 - s : 0;
            end
        end
        return 0;
    endfunction

    function automatic int m_fwd_e(int r);
        if (mm(1, r) && pipe[1].tnew == 0) return 2;
        if (mm(2, r)) return 1;
        return 0;
    endfunction

    task automatic model_clear();
        for (int s = 0; s < 3; s++) pipe[s] = empty_rec();
        busy_end = cyc;
        exp_cnt = 0;
    endtask

    task automatic model_advance();
        bit st;
        rec_t nr;
        st = m_stall();
        if (pipe[0].valid && pipe[0].md_start)
            busy_end = cyc + 1 + (pipe[0].md_div ? DIV_LAT : MULT_LAT);
        if (st && exp_cnt < 64'hFFFF_FFFF) exp_cnt++;
        pipe[2] = pipe[1];
        pipe[1] = pipe[0];
        if (pipe[1].tnew > 0) pipe[1].tnew--;
        nr = empty_rec();
        if (!st) begin
            nr.valid = 1; nr.wr = d_regwrite; nr.a3 = d_a3; nr.tnew = d_tnew;
            nr.rs = d_rs; nr.rt = d_rt; nr.md_start = d_md_start;
            nr.md_div = d_md_start && d_md_div;
        end
        pipe[0] = nr;
        cyc++;
    endtask

    task automatic compare_all();
        chk("stall", 32'(stall), 32'(m_stall()));
        chk("fwd_rs_d", 32'(fwd_rs_d), 32'(m_fwd_d(int'(d_rs))));
        chk("fwd_rt_d", 32'(fwd_rt_d), 32'(m_fwd_d(int'(d_rt))));
        chk("fwd_rs_e", 32'(fwd_rs_e), 32'(m_fwd_e(pipe[0].rs)));
        chk("fwd_rt_e", 32'(fwd_rt_e), 32'(m_fwd_e(pipe[0].rt)));
        chk("fwd_rt_m", 32'(fwd_rt_m), 32'(mm(2, pipe[1].rt)));
        chk("md_busy", 32'(md_busy), 32'(m_busy()));
        chk("stall_cnt", stall_cnt, exp_cnt[31:0]);
    endtask

    task automatic step();
        @(negedge clk);
        compare_all();
        @(posedge clk);
        if (reset) model_clear();
        else model_advance();
        #1;
    endtask

    task automatic set_d(input int rs, input int use_rs, input int tuse_rs,
                         input int rt, input int use_rt, input int tuse_rt,
                         input int wr, input int a3, input int tnew,
                         input int md_use, input int md_start, input int md_div);
        d_rs = rs[REG_AW-1:0]; d_use_rs = use_rs[0]; d_tuse_rs = tuse_rs[TW-1:0];
        d_rt = rt[REG_AW-1:0]; d_use_rt = use_rt[0]; d_tuse_rt = tuse_rt[TW-1:0];
        d_regwrite = wr[0]; d_a3 = a3[REG_AW-1:0]; d_tnew = tnew[TW-1:0];
        d_md_use = md_use[0]; d_md_start = md_start[0]; d_md_div = md_div[0];
    endtask

    task automatic set_nop();
        set_d(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_stall"}, 32'(stall), 0);
        chk({tag, "_md_busy"}, 32'(md_busy), 0);
        chk({tag, "_fwd"}, 32'({fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e, fwd_rt_m}), 0);
        chk({tag, "_stall_cnt"}, stall_cnt, 0);
    endtask

    // Called at posedge+1; reset takes effect asynchronously right away.
    task automatic do_reset(input int n);
        reset = 1'b1;
        model_clear();
        #1;
        check_zero("rst");
        for (int i = 0; i < n; i++) step();
        reset = 1'b0;
    endtask

    function automatic int rand_reg();
        return ($urandom_range(0, 15) == 0) ? 31 : int'($urandom_range(0, 3));
    endfunction

    int stalls, md_use_r, md_start_r;

    initial begin
        n_checks = 0; n_fail = 0; cyc = 0; busy_end = 0; exp_cnt = 0;
        reset = 1'b1;
        set_nop();
        d_rs = 5'd1; d_use_rs = 1'b1;
        model_clear();
        #2;
        check_zero("por");
        step();
        step();
        reset = 1'b0;

        // lw $1 ; addu $2,$1,$3
        do_reset(1); set_nop();
        set_d(0, 0, 0, 0, 0, 0, 1, 1, 2, 0, 0, 0); step();
        set_d(1, 1, 1, 3, 1, 1, 1, 2, 1, 0, 0, 0); #1;
        chk("lu_stall1", 32'(stall), 1);
        step(); #1;
        chk("lu_stall2", 32'(stall), 0);
        step(); set_nop(); #1;
        chk("lu_fwd_rs_e", 32'(fwd_rs_e), 1);
        step();

        // addu $1 ; beq $1,$0
        do_reset(1); set_nop();
        set_d(0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0); step();
        set_d(1, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0); #1;
        chk("br_stall1", 32'(stall), 1);
        step(); #1;
        chk("br_stall2", 32'(stall), 0);
        chk("br_fwd_rs_d", 32'(fwd_rs_d), 2);
        step();

        // jal ; jr $31
        do_reset(1); set_nop();
        set_d(0, 0, 0, 0, 0, 0, 1, 31, 0, 0, 0, 0); step();
        set_d(31, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); #1;
        chk("jr_stall", 32'(stall), 0);
        chk("jr_fwd_rs_d", 32'(fwd_rs_d), 3);
        step();

        // write $0 ; read $0
        do_reset(1); set_nop();
        set_d(0, 0, 0, 0, 0, 0, 1, 0, 2, 0, 0, 0); step();
        set_d(0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0); #1;
        chk("r0_stall", 32'(stall), 0);
        chk("r0_fwd_d", 32'({fwd_rs_d, fwd_rt_d}), 0);
        step(); #1;
        chk("r0_fwd_e", 32'({fwd_rs_e, fwd_rt_e, fwd_rt_m}), 0);
        step();

        // div ; mflo
        do_reset(1); set_nop();
        set_d(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1); step();
        set_d(0, 0, 0, 0, 0, 0, 1, 5, 1, 1, 0, 0);
        stalls = 0;
        for (int i = 0; i < 30; i++) begin
            #1;
            if (!stall) break;
            stalls++;
            step();
        end
        chk("md_stalls", 32'(stalls), 11);
        chk("md_stall_cnt", stall_cnt, 11);
        chk("md_busy_done", 32'(md_busy), 0);
        step();

        // reset during a load-use stall with a divide in flight
        do_reset(1); set_nop();
        set_d(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0); step();
        set_d(0, 0, 0, 0, 0, 0, 1, 1, 2, 0, 0, 0); step();
        set_d(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); step(); #1;
        chk("rs_pre_stall", 32'(stall), 1);
        chk("rs_pre_cnt", stall_cnt, 1);
        chk("rs_pre_busy", 32'(md_busy), 1);
        do_reset(1); #1;
        chk("rs_post_stall", 32'(stall), 0);
        chk("rs_post_fwd", 32'(fwd_rs_d), 0);
        step();

        // randomized traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset(int'($urandom_range(1, 2)));
            end
            md_use_r   = ($urandom_range(0, 9) == 0) ? 1 : 0;
            md_start_r = md_use_r != 0 && $urandom_range(0, 1) == 1 ? 1 : 0;
            set_d(rand_reg(), int'($urandom_range(0, 1)), int'($urandom_range(0, 2)),
                  rand_reg(), int'($urandom_range(0, 1)), int'($urandom_range(0, 2)),
                  int'($urandom_range(0, 1)), rand_reg(), int'($urandom_range(0, 2)),
                  md_use_r, md_start_r, int'($urandom_range(0, 1)));
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
